// File: rtl/pipe_hazard_ctrl.sv
// Hazard and flow-control unit for the 5-stage RV32I pipeline: branch bubbles/redirects,
// load-use interlock, data-memory wait with sticky timeout, and saturating perf counters.
module pipe_hazard_ctrl #(
  parameter int BRANCH_MODE      = 1,
  parameter int REDIRECT_BUBBLES = 2,
  parameter int MEM_TIMEOUT      = 255,
  parameter int CNT_W            = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       opcode_fetch,
  input  logic [6:0]       opcode_dec,
  input  logic [6:0]       opcode_ex,
  input  logic [4:0]       rs1_dec,
  input  logic [4:0]       rs2_dec,
  input  logic [4:0]       rd_ex,
  input  logic             branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             stall_fetch,
  output logic             stall_dec,
  output logic             stall_ex,
  output logic             stall_mem,
  output logic             nop_output_fetch,
  output logic             nop_output_dec,
  output logic [1:0]       fetch_sel,
  output logic             mem_error,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_cycles,
  output logic [1:0]       dbg_state
);
  localparam logic [1:0] FETCH_SEL_PC     = 2'd0;
  localparam logic [1:0] FETCH_SEL_BRANCH = 2'd1;
  localparam logic [1:0] FETCH_SEL_NOP    = 2'd2;
  localparam logic [6:0] OP_LOAD          = 7'b0000011;

  localparam int                WAIT_W   = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);
  localparam logic [2:0]        BUB_INIT = 3'(REDIRECT_BUBBLES - 1);

  typedef enum logic [1:0] {
    S_RUN      = 2'd0,
    S_MEM_WAIT = 2'd1,
    S_REDIRECT = 2'd2
  } state_t;

  state_t            r_state;
  logic [WAIT_W-1:0] r_wait_cnt;
  logic [2:0]        r_bub_cnt;
  logic              r_mem_error;
  logic [CNT_W-1:0]  r_stall_cnt;
  logic [CNT_W-1:0]  r_flush_cnt;

  logic       w_mem_stall;
  logic       w_load_use;
  logic       w_ctl_bubble;
  logic       w_stall_f, w_stall_d, w_stall_x, w_stall_m;
  logic       w_nop_f, w_nop_d;
  logic [1:0] w_sel;

  function automatic logic is_ctl(input logic [6:0] op);
    return (op == 7'b1100011) || (op == 7'b1101111) || (op == 7'b1100111);
  endfunction

  // mem_req is a request held until mem_ready completes it; ready in the same cycle costs nothing.
  assign w_mem_stall  = mem_req && !mem_ready;
  assign w_load_use   = (opcode_ex == OP_LOAD) && (rd_ex != 5'd0) &&
                        ((rd_ex == rs1_dec) || (rd_ex == rs2_dec));
  assign w_ctl_bubble = (BRANCH_MODE == 0) && (is_ctl(opcode_fetch) || is_ctl(opcode_dec));

  always_comb begin
    w_stall_f = 1'b0;
    w_stall_d = 1'b0;
    w_stall_x = 1'b0;
    w_stall_m = 1'b0;
    w_nop_f   = 1'b0;
    w_nop_d   = 1'b0;
    w_sel     = FETCH_SEL_PC;
    if (!rst) begin
      case (r_state)
        S_RUN: begin
          if (w_mem_stall) begin
            {w_stall_f, w_stall_d, w_stall_x, w_stall_m} = 4'b1111;
            w_sel = FETCH_SEL_NOP;
          end else if (branch_taken) begin
            w_nop_f = 1'b1;
            w_nop_d = 1'b1;
            w_sel   = FETCH_SEL_BRANCH;
          end else if (w_load_use) begin
            w_stall_f = 1'b1;
            w_stall_d = 1'b1;
            w_nop_d   = 1'b1;
            w_sel     = FETCH_SEL_NOP;
          end else if (w_ctl_bubble) begin
            w_nop_f = 1'b1;
            w_sel   = FETCH_SEL_NOP;
          end
        end
        S_MEM_WAIT: begin
          {w_stall_f, w_stall_d, w_stall_x, w_stall_m} = 4'b1111;
          w_sel = FETCH_SEL_NOP;
        end
        S_REDIRECT: begin
          // A memory stall still has to hold MEM; the leftover bubbles are abandoned.
          if (w_mem_stall) begin
            {w_stall_f, w_stall_d, w_stall_x, w_stall_m} = 4'b1111;
            w_sel = FETCH_SEL_NOP;
          end else begin
            w_nop_f = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_RUN;
      r_wait_cnt  <= '0;
      r_bub_cnt   <= '0;
      r_mem_error <= 1'b0;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_stall_f && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if (w_nop_f && (r_flush_cnt != '1))   r_flush_cnt <= r_flush_cnt + CNT_W'(1);
      if ((r_state != S_MEM_WAIT) && w_mem_stall) begin
        r_state    <= S_MEM_WAIT;
        r_wait_cnt <= WAIT_W'(1);
        if (WAIT_MAX == WAIT_W'(1)) r_mem_error <= 1'b1;
      end else begin
        case (r_state)
          S_RUN: begin
            if (branch_taken && (BUB_INIT != 3'd0)) begin
              r_state   <= S_REDIRECT;
              r_bub_cnt <= BUB_INIT;
            end
          end
          S_MEM_WAIT: begin
            // Waiting continues past the timeout; only the error flag reports it.
            if (mem_ready) begin
              r_state <= S_RUN;
            end else if (r_wait_cnt != WAIT_MAX) begin
              r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
              if (r_wait_cnt == WAIT_MAX - WAIT_W'(1)) r_mem_error <= 1'b1;
            end
          end
          S_REDIRECT: begin
            if (r_bub_cnt <= 3'd1) r_state <= S_RUN;
            else                   r_bub_cnt <= r_bub_cnt - 3'd1;
          end
          default: r_state <= S_RUN;
        endcase
      end
    end
  end

  assign stall_fetch      = w_stall_f;
  assign stall_dec        = w_stall_d;
  assign stall_ex         = w_stall_x;
  assign stall_mem        = w_stall_m;
  assign nop_output_fetch = w_nop_f;
  assign nop_output_dec   = w_nop_d;
  assign fetch_sel        = w_sel;
  assign mem_error        = r_mem_error && !rst;
  assign stall_cycles     = rst ? '0 : r_stall_cnt;
  assign flush_cycles     = rst ? '0 : r_flush_cnt;
  assign dbg_state        = rst ? 2'b00 : r_state;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: a predict-not-taken instance (timeout 4) and a bubble-mode
// instance share stimulus; per-step expectations go through scoreboard queues.
module tb_pipe_hazard_ctrl;
  localparam int         W       = 11;
  localparam logic [1:0] SEL_PC  = 2'd0;
  localparam logic [1:0] SEL_BR  = 2'd1;
  localparam logic [1:0] SEL_NOP = 2'd2;
  localparam logic [1:0] RUN     = 2'd0;
  localparam logic [1:0] MWAIT   = 2'd1;
  localparam logic [1:0] REDIR   = 2'd2;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_LD   = 7'b0000011;
  localparam logic [6:0] OP_ST   = 7'b0100011;
  localparam logic [6:0] OP_B    = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;

  // ctl = {rst, branch_taken, mem_req, mem_ready}; chk = {check main, check mode0}
  typedef struct packed {
    logic [3:0]   ctl;
    logic [6:0]   opf, opd, ope;
    logic [4:0]   rs1, rs2, rd;
    logic [1:0]   chk;
    logic [W-1:0] exp, exp0;
  } step_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [6:0] opcode_fetch = OP_I, opcode_dec = OP_I, opcode_ex = OP_I;
  logic [4:0] rs1_dec = '0, rs2_dec = '0, rd_ex = '0;
  logic branch_taken = 1'b0, mem_req = 1'b0, mem_ready = 1'b0;

  logic sf, sd, sx, sm, nf, nd, me;
  logic [1:0] fsel, dst;
  logic [15:0] stall_cycles, flush_cycles;
  logic sf0, sd0, sx0, sm0, nf0, nd0, me0;
  logic [1:0] fsel0, dst0;
  logic [15:0] stall0, flush0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp0_q[$];
  int n_vec = 0;
  int n_err = 0;
  logic [15:0] exp_stall = '0, exp_flush = '0;
  logic cnt_ok = 1'b0;

  pipe_hazard_ctrl #(.BRANCH_MODE(1), .REDIRECT_BUBBLES(2), .MEM_TIMEOUT(4), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .opcode_fetch(opcode_fetch), .opcode_dec(opcode_dec),
    .opcode_ex(opcode_ex), .rs1_dec(rs1_dec), .rs2_dec(rs2_dec), .rd_ex(rd_ex),
    .branch_taken(branch_taken), .mem_req(mem_req), .mem_ready(mem_ready),
    .stall_fetch(sf), .stall_dec(sd), .stall_ex(sx), .stall_mem(sm),
    .nop_output_fetch(nf), .nop_output_dec(nd), .fetch_sel(fsel), .mem_error(me),
    .stall_cycles(stall_cycles), .flush_cycles(flush_cycles), .dbg_state(dst)
  );

  pipe_hazard_ctrl #(.BRANCH_MODE(0), .REDIRECT_BUBBLES(2), .MEM_TIMEOUT(4), .CNT_W(16)) u_dut0 (
    .clk(clk), .rst(rst), .opcode_fetch(opcode_fetch), .opcode_dec(opcode_dec),
    .opcode_ex(opcode_ex), .rs1_dec(rs1_dec), .rs2_dec(rs2_dec), .rd_ex(rd_ex),
    .branch_taken(branch_taken), .mem_req(mem_req), .mem_ready(mem_ready),
    .stall_fetch(sf0), .stall_dec(sd0), .stall_ex(sx0), .stall_mem(sm0),
    .nop_output_fetch(nf0), .nop_output_dec(nd0), .fetch_sel(fsel0), .mem_error(me0),
    .stall_cycles(stall0), .flush_cycles(flush0), .dbg_state(dst0)
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: run did not complete, vectors=%0d", n_vec);
    $fatal(1);
  end

  // Vector layout: {stall f,d,ex,mem, nop f,d, fetch_sel, mem_error, state}
  function automatic logic [W-1:0] mk(logic [3:0] st, logic [1:0] nop, logic [1:0] sel,
                                      logic err, logic [1:0] s);
    return {st, nop, sel, err, s};
  endfunction

  function automatic step_t stp(logic [3:0] ctl, logic [6:0] f, logic [6:0] d, logic [6:0] e,
                                logic [4:0] a1, logic [4:0] a2, logic [4:0] r, logic [1:0] c,
                                logic [W-1:0] x, logic [W-1:0] x0);
    step_t t;
    t.ctl = ctl; t.opf = f; t.opd = d; t.ope = e;
    t.rs1 = a1; t.rs2 = a2; t.rd = r; t.chk = c; t.exp = x; t.exp0 = x0;
    return t;
  endfunction

  function automatic logic [W-1:0] main_vec();
    return {sf, sd, sx, sm, nf, nd, fsel, me, dst};
  endfunction

  function automatic logic [W-1:0] mode0_vec();
    return {sf0, sd0, sx0, sm0, nf0, nd0, fsel0, me0, dst0};
  endfunction

  // Driver: inputs change 1 time unit after the rising edge
  task automatic drive(input step_t t);
    @(posedge clk);
    #1;
    {rst, branch_taken, mem_req, mem_ready} = t.ctl;
    opcode_fetch = t.opf; opcode_dec = t.opd; opcode_ex = t.ope;
    rs1_dec = t.rs1; rs2_dec = t.rs2; rd_ex = t.rd;
  endtask

  task automatic update_model(input step_t t);
    if (t.ctl[3]) begin
      exp_stall = '0; exp_flush = '0; cnt_ok = 1'b1;
    end else if (!t.chk[1]) begin
      cnt_ok = 1'b0;
    end else begin
      exp_stall += 16'(t.exp[10]);
      exp_flush += 16'(t.exp[6]);
    end
  endtask

  task automatic test_reset();
    step_t t[$];
    logic [W-1:0] want, want0;
    t.push_back(stp(4'b1110, OP_B, OP_I, OP_LD, 5'd5, 5'd0, 5'd5, 2'b11, '0, '0));
    t.push_back(stp(4'b1000, OP_I, OP_I, OP_I, 5'd0, 5'd0, 5'd0, 2'b11, '0, '0));
    t.push_back(stp(4'b0000, OP_I, OP_I, OP_I, 5'd0, 5'd0, 5'd0, 2'b11,
                    mk(4'b0000, 2'b00, SEL_PC, 1'b0, RUN), mk(4'b0000, 2'b00, SEL_PC, 1'b0, RUN)));
    foreach (t[i]) begin
      drive(t[i]);
      exp_q.push_back(t[i].exp);
      exp0_q.push_back(t[i].exp0);
      @(negedge clk);
      want = exp_q.pop_front(); want0 = exp0_q.pop_front();
      n_vec += 2;
      if (main_vec() !== want) begin
        n_err++; $display("FAIL reset[%0d] outputs got=%b exp=%b", i, main_vec(), want);
      end
      if (mode0_vec() !== want0) begin
        n_err++; $display("FAIL reset[%0d] mode0 outputs got=%b exp=%b", i, mode0_vec(), want0);
      end
      n_vec++;
      if (stall_cycles !== 16'd0 || flush_cycles !== 16'd0 || stall0 !== 16'd0 || flush0 !== 16'd0) begin
        n_err++;
        $display("FAIL reset[%0d] counters got=%0d/%0d/%0d/%0d exp=0/0/0/0",
                 i, stall_cycles, flush_cycles, stall0, flush0);
      end
      update_model(t[i]);
    end
  endtask

  task automatic test_load_use();
    step_t t[$];
    logic [W-1:0] want;
    logic [W-1:0] lu;
    logic [W-1:0] idle;
    lu   = mk(4'b1100, 2'b01, SEL_NOP, 1'b0, RUN);
    idle = mk(4'b0000, 2'b00, SEL_PC, 1'b0, RUN);
    t.push_back(stp(4'b0000, OP_I, OP_I, OP_LD, 5'd5, 5'd0, 5'd5, 2'b10, lu, '0));
    t.push_back(stp(4'b0000, OP_I, OP_I, OP_I,  5'd5, 5'd0, 5'd5, 2'b10, idle, '0));
    t.push_back(stp(4'b0000, OP_I, OP_I, OP_LD, 5'd0, 5'd0, 5'd0, 2'b10, idle, '0));
    t.push_back(stp(4'b0000, OP_I, OP_I, OP_LD, 5'd1, 5'd7, 5'd7, 2'b10, lu, '0));
    t.push_back(stp(4'b0000, OP_I, OP_I, OP_LD, 5'd1, 5'd2, 5'd7, 2'b10, idle, '0));
    t.push_back(stp(4'b0000, OP_I, OP_I, OP_ST, 5'd5, 5'd5, 5'd5, 2'b10, idle, '0));
    foreach (t[i]) begin
      drive(t[i]);
      exp_q.push_back(t[i].exp);
      @(negedge clk);
      want = exp_q.pop_front();
      n_vec++;
      if (main_vec() !== want) begin
        n_err++; $display("FAIL load_use[%0d] outputs got=%b exp=%b", i, main_vec(), want);
      end
      n_vec++;
      if (stall_cycles !== exp_stall || flush_cycles !== exp_flush) begin
        n_err++;
        $display("FAIL load_use[%0d] counters got=%0d/%0d exp=%0d/%0d",
                 i, stall_cycles, flush_cycles, exp_stall, exp_flush);
      end
      update_model(t[i]);
    end
  endtask

  task automatic test_redirect();
    step_t t[$];
    logic [W-1:0] want;
    t.push_back(stp(4'b0100, OP_I, OP_I, OP_I, 5'd0, 5'd0, 5'd0, 2'b10,
                    mk(4'b0000, 2'b11, SEL_BR, 1'b0, RUN), '0));
    t.push_back(stp(4'b0000, OP_I, OP_I, OP_I, 5'd0, 5'd0, 5'd0, 2'b10,
                    mk(4'b0000, 2'b10, SEL_PC, 1'b0, REDIR), '0));
    t.push_back(stp(4'b0000, OP_I, OP_I, OP_I, 5'd0, 5'd0, 5'd0, 2'b10,
                    mk(4'b0000, 2'b00, SEL_PC, 1'b0, RUN), '0));
    t.push_back(stp(4'b0000, OP_I, OP_I, OP_I, 5'd0, 5'd0, 5'd0, 2'b10,
                    mk(4'b0000, 2'b00, SEL_PC, 1'b0, RUN), '0));
    foreach (t[i]) begin
      drive(t[i]);
      exp_q.push_back(t[i].exp);
      @(negedge clk);
      want = exp_q.pop_front();
      n_vec++;
      if (main_vec() !== want) begin
        n_err++; $display("FAIL redirect[%0d] outputs got=%b exp=%b", i, main_vec(), want);
      end
      n_vec++;
      if (stall_cycles !== exp_stall || flush_cycles !== exp_flush) begin
        n_err++;
        $display("FAIL redirect[%0d] counters got=%0d/%0d exp=%0d/%0d",
                 i, stall_cycles, flush_cycles, exp_stall, exp_flush);
      end
      update_model(t[i]);
    end
  endtask

  task automatic test_mem_wait();
    step_t t[$];
    logic [W-1:0] want;
    logic [W-1:0] st_run;
    logic [W-1:0] st_wait;
    st_run  = mk(4'b1111, 2'b00, SEL_NOP, 1'b0, RUN);
    st_wait = mk(4'b1111, 2'b00, SEL_NOP, 1'b0, MWAIT);
    t.push_back(stp(4'b0110, OP_I, OP_I, OP_I, 5'd0, 5'd0, 5'd0, 2'b10, st_run, '0));
    t.push_back(stp(4'b0110, OP_I, OP_I, OP_I, 5'd0, 5'd0, 5'd0, 2'b10, st_wait, '0));
    t.push_back(stp(4'b0110, OP_I, OP_I, OP_I, 5'd0, 5'd0, 5'd0, 2'b10, st_wait, '0));
    t.push_back(stp(4'b0111, OP_I, OP_I, OP_I, 5'd0, 5'd0, 5'd0, 2'b10, st_wait, '0));
    t.push_back(stp(4'b0100, OP_I, OP_I, OP_I, 5'd0, 5'd0, 5'd0, 2'b10,
                    mk(4'b0000, 2'b11, SEL_BR, 1'b0, RUN), '0));
    t.push_back(stp(4'b0000, OP_I, OP_I, OP_I, 5'd0, 5'd0, 5'd0, 2'b10,
                    mk(4'b0000, 2'b10, SEL_PC, 1'b0, REDIR), '0));
    t.push_back(stp(4'b0000, OP_I, OP_I, OP_I, 5'd0, 5'd0, 5'd0, 2'b10,
                    mk(4'b0000, 2'b00, SEL_PC, 1'b0, RUN), '0));
    t.push_back(stp(4'b0011, OP_I, OP_I, OP_I, 5'd0, 5'd0, 5'd0, 2'b10,
                    mk(4'b0000, 2'b00, SEL_PC, 1'b0, RUN), '0));
    foreach (t[i]) begin
      drive(t[i]);
      exp_q.push_back(t[i].exp);
      @(negedge clk);
      want = exp_q.pop_front();
      n_vec++;
      if (main_vec() !== want) begin
        n_err++; $display("FAIL mem_wait[%0d] outputs got=%b exp=%b", i, main_vec(), want);
      end
      n_vec++;
      if (stall_cycles !== exp_stall || flush_cycles !== exp_flush) begin
        n_err++;
        $display("FAIL mem_wait[%0d] counters got=%0d/%0d exp=%0d/%0d",
                 i, stall_cycles, flush_cycles, exp_stall, exp_flush);
      end
      update_model(t[i]);
    end
  endtask

  task automatic test_timeout();
    step_t t[$];
    logic [W-1:0] want;
    t.push_back(stp(4'b0010, OP_I, OP_I, OP_I, 5'd0, 5'd0, 5'd0, 2'b10,
                    mk(4'b1111, 2'b00, SEL_NOP, 1'b0, RUN), '0));
    for (int k = 1; k < 6; k++) begin
      t.push_back(stp(4'b0010, OP_I, OP_I, OP_I, 5'd0, 5'd0, 5'd0, 2'b10,
                      mk(4'b1111, 2'b00, SEL_NOP, (k >= 4), MWAIT), '0));
    end
    t.push_back(stp(4'b0011, OP_I, OP_I, OP_I, 5'd0, 5'd0, 5'd0, 2'b10,
                    mk(4'b1111, 2'b00, SEL_NOP, 1'b1, MWAIT), '0));
    t.push_back(stp(4'b0000, OP_I, OP_I, OP_I, 5'd0, 5'd0, 5'd0, 2'b10,
                    mk(4'b0000, 2'b00, SEL_PC, 1'b1, RUN), '0));
    t.push_back(stp(4'b1000, OP_I, OP_I, OP_I, 5'd0, 5'd0, 5'd0, 2'b10, '0, '0));
    t.push_back(stp(4'b0000, OP_I, OP_I, OP_I, 5'd0, 5'd0, 5'd0, 2'b10,
                    mk(4'b0000, 2'b00, SEL_PC, 1'b0, RUN), '0));
    foreach (t[i]) begin
      drive(t[i]);
      exp_q.push_back(t[i].exp);
      @(negedge clk);
      want = exp_q.pop_front();
      n_vec++;
      if (main_vec() !== want) begin
        n_err++; $display("FAIL timeout[%0d] outputs got=%b exp=%b", i, main_vec(), want);
      end
      n_vec++;
      if (stall_cycles !== (t[i].ctl[3] ? 16'd0 : exp_stall) ||
          flush_cycles !== (t[i].ctl[3] ? 16'd0 : exp_flush)) begin
        n_err++;
        $display("FAIL timeout[%0d] counters got=%0d/%0d exp=%0d/%0d",
                 i, stall_cycles, flush_cycles, exp_stall, exp_flush);
      end
      update_model(t[i]);
    end
  endtask

  task automatic test_mode0();
    step_t t[$];
    logic [W-1:0] want, want0;
    logic [W-1:0] idle;
    logic [W-1:0] bub;
    idle = mk(4'b0000, 2'b00, SEL_PC, 1'b0, RUN);
    bub  = mk(4'b0000, 2'b10, SEL_NOP, 1'b0, RUN);
    t.push_back(stp(4'b0000, OP_B,    OP_I,    OP_I, 5'd0, 5'd0, 5'd0, 2'b11, idle, bub));
    t.push_back(stp(4'b0000, OP_I,    OP_B,    OP_I, 5'd0, 5'd0, 5'd0, 2'b11, idle, bub));
    t.push_back(stp(4'b0000, OP_JAL,  OP_I,    OP_I, 5'd0, 5'd0, 5'd0, 2'b11, idle, bub));
    t.push_back(stp(4'b0000, OP_I,    OP_JALR, OP_I, 5'd0, 5'd0, 5'd0, 2'b11, idle, bub));
    t.push_back(stp(4'b0000, OP_ST,   OP_I,    OP_I, 5'd0, 5'd0, 5'd0, 2'b11, idle, idle));
    t.push_back(stp(4'b0000, OP_I,    OP_I,    OP_I, 5'd0, 5'd0, 5'd0, 2'b11, idle, idle));
    foreach (t[i]) begin
      drive(t[i]);
      exp_q.push_back(t[i].exp);
      exp0_q.push_back(t[i].exp0);
      @(negedge clk);
      want = exp_q.pop_front(); want0 = exp0_q.pop_front();
      n_vec += 2;
      if (main_vec() !== want) begin
        n_err++; $display("FAIL mode0[%0d] mode1 outputs got=%b exp=%b", i, main_vec(), want);
      end
      if (mode0_vec() !== want0) begin
        n_err++; $display("FAIL mode0[%0d] mode0 outputs got=%b exp=%b", i, mode0_vec(), want0);
      end
      update_model(t[i]);
    end
  endtask

  task automatic test_back_to_back();
    step_t t[$];
    logic [W-1:0] want, want0;
    logic [W-1:0] v[9];
    v[0] = mk(4'b1111, 2'b00, SEL_NOP, 1'b0, RUN);
    v[1] = mk(4'b1111, 2'b00, SEL_NOP, 1'b0, MWAIT);
    v[2] = mk(4'b0000, 2'b11, SEL_BR,  1'b0, RUN);
    v[3] = mk(4'b0000, 2'b10, SEL_PC,  1'b0, REDIR);
    v[4] = mk(4'b1100, 2'b01, SEL_NOP, 1'b0, RUN);
    v[5] = mk(4'b0000, 2'b11, SEL_BR,  1'b0, RUN);
    v[6] = '0;
    v[7] = mk(4'b1111, 2'b00, SEL_NOP, 1'b0, MWAIT);
    v[8] = mk(4'b0000, 2'b00, SEL_PC,  1'b0, RUN);
    t.push_back(stp(4'b0110, OP_B, OP_I, OP_LD, 5'd5, 5'd0, 5'd5, 2'b11, v[0], v[0]));
    t.push_back(stp(4'b0111, OP_B, OP_I, OP_LD, 5'd5, 5'd0, 5'd5, 2'b11, v[1], v[1]));
    t.push_back(stp(4'b0100, OP_B, OP_I, OP_LD, 5'd5, 5'd0, 5'd5, 2'b11, v[2], v[2]));
    t.push_back(stp(4'b0000, OP_I, OP_I, OP_I,  5'd0, 5'd0, 5'd0, 2'b11, v[3], v[3]));
    t.push_back(stp(4'b0000, OP_B, OP_I, OP_LD, 5'd0, 5'd9, 5'd9, 2'b11, v[4], v[4]));
    t.push_back(stp(4'b0100, OP_I, OP_I, OP_I,  5'd0, 5'd0, 5'd0, 2'b11, v[5], v[5]));
    t.push_back(stp(4'b0010, OP_I, OP_I, OP_I,  5'd0, 5'd0, 5'd0, 2'b00, v[6], v[6]));
    t.push_back(stp(4'b0011, OP_I, OP_I, OP_I,  5'd0, 5'd0, 5'd0, 2'b11, v[7], v[7]));
    t.push_back(stp(4'b0000, OP_I, OP_I, OP_I,  5'd0, 5'd0, 5'd0, 2'b11, v[8], v[8]));
    foreach (t[i]) begin
      drive(t[i]);
      if (t[i].chk[1]) exp_q.push_back(t[i].exp);
      if (t[i].chk[0]) exp0_q.push_back(t[i].exp0);
      @(negedge clk);
      if (t[i].chk[1]) begin
        want = exp_q.pop_front();
        n_vec++;
        if (main_vec() !== want) begin
          n_err++; $display("FAIL back_to_back[%0d] outputs got=%b exp=%b", i, main_vec(), want);
        end
      end
      if (t[i].chk[0]) begin
        want0 = exp0_q.pop_front();
        n_vec++;
        if (mode0_vec() !== want0) begin
          n_err++; $display("FAIL back_to_back[%0d] mode0 outputs got=%b exp=%b", i, mode0_vec(), want0);
        end
      end
      if (cnt_ok) begin
        n_vec++;
        if (stall_cycles !== exp_stall || flush_cycles !== exp_flush) begin
          n_err++;
          $display("FAIL back_to_back[%0d] counters got=%0d/%0d exp=%0d/%0d",
                   i, stall_cycles, flush_cycles, exp_stall, exp_flush);
        end
      end
      update_model(t[i]);
    end
  endtask

  task automatic test_reset_mid();
    step_t t[$];
    logic [W-1:0] want;
    t.push_back(stp(4'b1000, OP_I, OP_I, OP_I, 5'd0, 5'd0, 5'd0, 2'b10, '0, '0));
    t.push_back(stp(4'b0100, OP_I, OP_I, OP_I, 5'd0, 5'd0, 5'd0, 2'b10,
                    mk(4'b0000, 2'b11, SEL_BR, 1'b0, RUN), '0));
    t.push_back(stp(4'b1000, OP_I, OP_I, OP_I, 5'd0, 5'd0, 5'd0, 2'b10, '0, '0));
    t.push_back(stp(4'b0000, OP_I, OP_I, OP_I, 5'd0, 5'd0, 5'd0, 2'b10,
                    mk(4'b0000, 2'b00, SEL_PC, 1'b0, RUN), '0));
    t.push_back(stp(4'b0010, OP_I, OP_I, OP_I, 5'd0, 5'd0, 5'd0, 2'b10,
                    mk(4'b1111, 2'b00, SEL_NOP, 1'b0, RUN), '0));
    t.push_back(stp(4'b0010, OP_I, OP_I, OP_I, 5'd0, 5'd0, 5'd0, 2'b10,
                    mk(4'b1111, 2'b00, SEL_NOP, 1'b0, MWAIT), '0));
    t.push_back(stp(4'b1010, OP_I, OP_I, OP_I, 5'd0, 5'd0, 5'd0, 2'b10, '0, '0));
    t.push_back(stp(4'b0000, OP_I, OP_I, OP_I, 5'd0, 5'd0, 5'd0, 2'b10,
                    mk(4'b0000, 2'b00, SEL_PC, 1'b0, RUN), '0));
    foreach (t[i]) begin
      drive(t[i]);
      exp_q.push_back(t[i].exp);
      @(negedge clk);
      want = exp_q.pop_front();
      n_vec++;
      if (main_vec() !== want) begin
        n_err++; $display("FAIL reset_mid[%0d] outputs got=%b exp=%b", i, main_vec(), want);
      end
      n_vec++;
      if (stall_cycles !== (t[i].ctl[3] ? 16'd0 : exp_stall) ||
          flush_cycles !== (t[i].ctl[3] ? 16'd0 : exp_flush)) begin
        n_err++;
        $display("FAIL reset_mid[%0d] counters got=%0d/%0d exp=%0d/%0d",
                 i, stall_cycles, flush_cycles, exp_stall, exp_flush);
      end
      update_model(t[i]);
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_redirect();
    test_mem_wait();
    test_timeout();
    test_mode0();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Parametrised hazard and flow-control unit for the 5-stage RV32I pipeline (FETCH/DEC/EX/MEM/WB). It generalises the combinational pipeline control:
- configurable branch handling (always-bubble or predict-not-taken);
- load-use interlock detection;
- a data-memory wait state machine with timeout;
- saturating stall/flush performance counters.

It drives the pipeline-register stall/NOP inputs and `fetch_sel`, using `FETCH_SEL_*` from `defines.vh`.

## Interface
Parameters:
- `BRANCH_MODE`, 1: 0 = bubble behind every B/JAL/JALR in FETCH/DEC; 1 = predict-not-taken, flush only on a resolved redirect.
- `REDIRECT_BUBBLES`, 2: cycles `nop_output_fetch` stays high after a redirect (range 1..7).
- `MEM_TIMEOUT`, 255: wait cycles before `mem_error` (≥1).
- `CNT_W`, 16: width of the performance counters.

Ports:
- `clk` in 1: clock. The block uses one clock.
- `rst` in 1: reset, synchronous, active-high.
- `opcode_fetch`, `opcode_dec`, `opcode_ex` in 7: opcodes per stage.
- `rs1_dec`, `rs2_dec` in 5: DEC source registers.
- `rd_ex` in 5: EX destination register.
- `branch_taken` in 1: EX resolved taken (B) or any JAL/JALR in EX.
- `mem_req` in 1: MEM stage issues a load/store.
- `mem_ready` in 1: data memory completes.
- `stall_fetch`, `stall_dec`, `stall_ex`, `stall_mem` out 1: hold the stage register.
- `nop_output_fetch` out 1: bubble into the FETCH→DEC register.
- `nop_output_dec` out 1: bubble into the DEC→EX register.
- `fetch_sel` out 2: `FETCH_SEL_PC` / `FETCH_SEL_BRANCH` / `FETCH_SEL_NOP`.
- `mem_error` out 1: sticky timeout flag.
- `stall_cycles`, `flush_cycles` out `CNT_W`: saturating counters.

## Operation
- **Control-transfer opcode:** `1100011`, `1101111` or `1100111`. **Load:** `0000011`.
- **FSM states:** RUN, MEM_WAIT, REDIRECT. Reset enters RUN.
- **Priority, highest first:** memory stall > redirect > load-use > mode-0 bubble.

**RUN**
- If `mem_req && !mem_ready`:
  - this cycle, assert all four stalls; `fetch_sel=FETCH_SEL_NOP`;
  - go to MEM_WAIT; the wait counter loads 1.
- Else if `branch_taken`:
  - `fetch_sel=FETCH_SEL_BRANCH`;
  - `nop_output_fetch=1` and `nop_output_dec=1`;
  - go to REDIRECT with the bubble counter = `REDIRECT_BUBBLES-1`. If that value is 0, stay in RUN.
- Else if load-use: `opcode_ex` is a load, `rd_ex!=0`, and `rd_ex` equals `rs1_dec` or `rs2_dec`. Then:
  - `stall_fetch=stall_dec=1`, `nop_output_dec=1`, `fetch_sel=FETCH_SEL_NOP`;
  - stay in RUN; this lasts one cycle, because the load advances.
- Else if `BRANCH_MODE==0` and `opcode_fetch` or `opcode_dec` is a control transfer: `nop_output_fetch=1`, `fetch_sel=FETCH_SEL_NOP`.
- Else `fetch_sel=FETCH_SEL_PC`.

**MEM_WAIT**
- All four stalls are high and `fetch_sel=FETCH_SEL_NOP`.
- Each cycle with `mem_ready=0`, the wait counter increments.
- When the counter reaches `MEM_TIMEOUT`, `mem_error` sets and stays set until `rst`. The FSM keeps waiting.
- When `mem_ready=1`, stalls still assert in that cycle; the next state is RUN.
- `branch_taken` is ignored while waiting. EX is frozen, so the redirect is taken in RUN afterwards.

**REDIRECT**
- Outputs: `nop_output_fetch=1`, `fetch_sel=FETCH_SEL_PC`. The new PC streams in and the bubbles cover the instruction-memory latency.
- The bubble counter decrements each cycle; at 0 the FSM returns to RUN.
- A `mem_req && !mem_ready` seen here goes to MEM_WAIT. The remaining bubbles are dropped; the branch already left EX.

**Counters** (saturate at all-ones, clear on `rst`)
- `stall_cycles` counts +1 every cycle `stall_fetch` is high.
- `flush_cycles` counts +1 every cycle `nop_output_fetch` is high.

## Timing
- All outputs are combinational from the inputs and the registered state/counters.
- State, counters and `mem_error` update on `posedge clk`.
- **In the `rst` cycle:**
  - outputs are all 0, and `fetch_sel=FETCH_SEL_PC`;
  - the FSM enters RUN and the counters clear.
- **After reset:** a `rst` asserted mid-MEM_WAIT or mid-REDIRECT returns to RUN on the next edge with no residual bubble.
- **Latencies:**
  - redirect squashes exactly `REDIRECT_BUBBLES` fetch slots;
  - load-use costs 1 cycle;
  - memory wait costs the N cycles until ready, plus the 0-cycle exit.
- `mem_req && mem_ready` in the same RUN cycle means no stall.

## Test plan
- **Load-use:** lw x5 in EX with `rd_ex=5`, `rs1_dec=5`.
  - One cycle: `stall_fetch=stall_dec=nop_output_dec=1`, `fetch_sel=FETCH_SEL_NOP`.
  - Same case with `rd_ex=0`: no stall.
- **Redirect:** `BRANCH_MODE=1`, `REDIRECT_BUBBLES=2`, `branch_taken` for one cycle.
  - Cycle 0: `fetch_sel=FETCH_SEL_BRANCH`, both NOPs high.
  - Cycle 1: `nop_output_fetch=1`.
  - Cycle 2: RUN, `flush_cycles=2`.
- **Memory wait:** `mem_req=1`, `mem_ready=0` for 3 cycles, then 1.
  - Stalls high for 4 cycles, RUN on cycle 5, `stall_cycles=4`.
  - `branch_taken` held high throughout has no effect until RUN.
- **Timeout:** `MEM_TIMEOUT=4`, `mem_ready` held 0.
  - `mem_error=1` from the 4th increment and stays set after ready.
  - `rst` clears it.
- **Mode 0:** `BRANCH_MODE=0`, opcode `1100011` in FETCH then DEC.
  - `nop_output_fetch=1` and `fetch_sel=FETCH_SEL_NOP` in both cycles.
- **Reset in REDIRECT:** `rst` during REDIRECT; outputs are 0 the next cycle; counters read 0.
